// File: rtl/sb_i2c_bus_arbiter_if.sv
// Signal bundle between the SB_I2C bus arbiter, its two fabric requesters and
// the shared SB_I2C system bus.
interface sb_i2c_bus_arbiter_if;
  logic       req0_valid;
  logic       req0_rw;
  logic [7:0] req0_adr;
  logic [7:0] req0_dat;
  logic       req0_acc;
  logic       req1_valid;
  logic       req1_rw;
  logic [7:0] req1_adr;
  logic [7:0] req1_dat;
  logic       req1_acc;
  logic       rsp0_done;
  logic       rsp1_done;
  logic       rsp_err;
  logic [7:0] rsp_dat;
  logic       busy;
  logic       sbstbi;
  logic       sbrwi;
  logic [7:0] sbadri;
  logic [7:0] sbdati;
  logic [7:0] sbdato;
  logic       sbacko;

  // Arbiter view: takes requests, drives the bus strobe and the responses.
  modport master (
    input  req0_valid, req0_rw, req0_adr, req0_dat,
    input  req1_valid, req1_rw, req1_adr, req1_dat,
    input  sbdato, sbacko,
    output req0_acc, req1_acc,
    output rsp0_done, rsp1_done, rsp_err, rsp_dat, busy,
    output sbstbi, sbrwi, sbadri, sbdati
  );

  // Environment view: requesters and SB_I2C instances.
  modport slave (
    output req0_valid, req0_rw, req0_adr, req0_dat,
    output req1_valid, req1_rw, req1_adr, req1_dat,
    output sbdato, sbacko,
    input  req0_acc, req1_acc,
    input  rsp0_done, rsp1_done, rsp_err, rsp_dat, busy,
    input  sbstbi, sbrwi, sbadri, sbdati
  );
endinterface

// File: rtl/sb_i2c_bus_arbiter.sv
// Two-requester round-robin arbiter and strobe/ack sequencer for the SB_I2C
// system bus, with a per-transaction acknowledge timeout.
module sb_i2c_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   sbclki,
  input  logic                   rst_n,
  sb_i2c_bus_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    DONE
  } state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic       last_q;
  logic       owner_q;
  logic [7:0] cnt_q;
  logic       sbstbi_q;
  logic       sbrwi_q;
  logic [7:0] sbadri_q;
  logic [7:0] sbdati_q;
  logic       done0_q;
  logic       done1_q;
  logic       err_q;
  logic [7:0] rsp_dat_q;
  logic       busy_q;

  logic       grant0;
  logic       grant1;
  logic       acc0;
  logic       acc1;

  // A lone requester always wins; under contention the non-last owner wins.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
    acc0   = (state_q == IDLE) & grant0;
    acc1   = (state_q == IDLE) & grant1;
  end

  always_ff @(posedge sbclki or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      sbstbi_q  <= 1'b0;
      sbrwi_q   <= 1'b0;
      sbadri_q  <= '0;
      sbdati_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      rsp_dat_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc0) begin
            sbrwi_q  <= bus.req0_rw;
            sbadri_q <= bus.req0_adr;
            sbdati_q <= bus.req0_dat;
            owner_q  <= 1'b0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            sbstbi_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= STROBE;
          end else if (acc1) begin
            sbrwi_q  <= bus.req1_rw;
            sbadri_q <= bus.req1_adr;
            sbdati_q <= bus.req1_dat;
            owner_q  <= 1'b1;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            sbstbi_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= STROBE;
          end
        end
        STROBE: begin
          // An ack in the final allowed cycle still completes normally.
          if (bus.sbacko) begin
            rsp_dat_q <= sbrwi_q ? 8'h00 : bus.sbdato;
            err_q     <= 1'b0;
            done0_q   <= ~owner_q;
            done1_q   <= owner_q;
            sbstbi_q  <= 1'b0;
            state_q   <= DONE;
          end else if (cnt_q == TMAX) begin
            rsp_dat_q <= 8'h00;
            err_q     <= 1'b1;
            done0_q   <= ~owner_q;
            done1_q   <= owner_q;
            sbstbi_q  <= 1'b0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          sbstbi_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_acc  = acc0;
  assign bus.req1_acc  = acc1;
  assign bus.rsp0_done = done0_q;
  assign bus.rsp1_done = done1_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.busy      = busy_q;
  assign bus.sbstbi    = sbstbi_q;
  assign bus.sbrwi     = sbrwi_q;
  assign bus.sbadri    = sbadri_q;
  assign bus.sbdati    = sbdati_q;

endmodule

// File: tb/tb_sb_i2c_bus_arbiter.sv
// Directed plus randomized bench for sb_i2c_bus_arbiter, checked against a
// transaction-level model of the arbitration and strobe/ack timing rules.
module tb_sb_i2c_bus_arbiter;
  localparam int TO = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sb_i2c_bus_arbiter_if bus ();

  sb_i2c_bus_arbiter #(.TIMEOUT(TO)) dut (
    .sbclki (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Requester-side model state.
  bit         v[2];
  logic       rw[2];
  logic [7:0] adr[2];
  logic [7:0] dat[2];
  bit         m_last;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req0_valid = v[0];
    bus.req0_rw    = rw[0];
    bus.req0_adr   = adr[0];
    bus.req0_dat   = dat[0];
    bus.req1_valid = v[1];
    bus.req1_rw    = rw[1];
    bus.req1_adr   = adr[1];
    bus.req1_dat   = dat[1];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction starting in an IDLE cycle. ack_at: strobe cycle carrying
  // sbacko (values beyond TO mean no ack). refill: winner stays valid with
  // a fresh request after its accept.
  task automatic do_txn(input bit late_ack, input int ack_at,
                        input logic [7:0] ack_dat, input bit refill);
    int         w;
    int         slen;
    bit         err;
    logic       erw;
    logic [7:0] eadr;
    logic [7:0] edt;
    logic [7:0] edat;
    w    = (v[0] && v[1]) ? (m_last ? 0 : 1) : (v[0] ? 0 : 1);
    m_last = w[0];
    erw  = rw[w];
    eadr = adr[w];
    edt  = dat[w];
    edat = 8'h00;
    if (ack_at >= 1 && ack_at <= TO) begin
      slen = ack_at;
      err  = 1'b0;
    end else begin
      slen = TO;
      err  = 1'b1;
    end
    drive();
    bus.sbacko = 1'b0;
    @(negedge clk);
    chk("acc0", {7'd0, bus.req0_acc}, {7'd0, w == 0});
    chk("acc1", {7'd0, bus.req1_acc}, {7'd0, w == 1});
    chk("busy_idle", {7'd0, bus.busy}, 8'd0);
    chk("idle_done0", {7'd0, bus.rsp0_done}, 8'd0);
    chk("idle_done1", {7'd0, bus.rsp1_done}, 8'd0);
    step();
    v[w]   = refill;
    rw[w]  = 1'($urandom);
    adr[w] = 8'($urandom);
    dat[w] = 8'($urandom);
    drive();
    for (int j = 1; j <= slen; j++) begin
      bus.sbacko = (j == ack_at);
      bus.sbdato = (j == ack_at) ? ack_dat : 8'($urandom);
      if (j == ack_at && !erw) edat = ack_dat;
      @(negedge clk);
      chk("stb_hi", {7'd0, bus.sbstbi}, 8'd1);
      chk("stb_rw", {7'd0, bus.sbrwi}, {7'd0, erw});
      chk("stb_adr", bus.sbadri, eadr);
      chk("stb_dat", bus.sbdati, edt);
      chk("stb_done", {6'd0, bus.rsp1_done, bus.rsp0_done}, 8'd0);
      chk("stb_busy", {7'd0, bus.busy}, 8'd1);
      chk("stb_acc", {6'd0, bus.req1_acc, bus.req0_acc}, 8'd0);
      step();
    end
    bus.sbacko = late_ack;
    bus.sbdato = 8'($urandom);
    @(negedge clk);
    chk("gap_stb", {7'd0, bus.sbstbi}, 8'd0);
    chk("done0", {7'd0, bus.rsp0_done}, {7'd0, w == 0});
    chk("done1", {7'd0, bus.rsp1_done}, {7'd0, w == 1});
    chk("rsp_err", {7'd0, bus.rsp_err}, {7'd0, err});
    chk("rsp_dat", bus.rsp_dat, edat);
    chk("gap_busy", {7'd0, bus.busy}, 8'd1);
    step();
    bus.sbacko = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_last = 1'b1;
    for (int r = 0; r < 2; r++) begin
      v[r] = 1'b0; rw[r] = 1'b0; adr[r] = 8'h00; dat[r] = 8'h00;
    end
    drive();
    bus.sbacko = 1'b0;
    bus.sbdato = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stb", {7'd0, bus.sbstbi}, 8'd0);
    chk("rst_rw", {7'd0, bus.sbrwi}, 8'd0);
    chk("rst_adr", bus.sbadri, 8'h00);
    chk("rst_dat", bus.sbdati, 8'h00);
    chk("rst_acc", {6'd0, bus.req1_acc, bus.req0_acc}, 8'd0);
    chk("rst_done", {6'd0, bus.rsp1_done, bus.rsp0_done}, 8'd0);
    chk("rst_err", {7'd0, bus.rsp_err}, 8'd0);
    chk("rst_rdat", bus.rsp_dat, 8'h00);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single read on port 0, ack in second strobe cycle.
    v[0] = 1'b1; rw[0] = 1'b0; adr[0] = 8'h19; dat[0] = 8'h00;
    do_txn(1'b0, 2, 8'hA5, 1'b0);

    // Single write on port 1, immediate ack.
    v[1] = 1'b1; rw[1] = 1'b1; adr[1] = 8'h38; dat[1] = 8'h5C;
    do_txn(1'b0, 1, 8'hFF, 1'b0);

    // Continuous contention: order 0,1,0,1 at 3-cycle spacing.
    v[0] = 1'b1; v[1] = 1'b1;
    for (int i = 0; i < 4; i++) do_txn(1'b0, 1, 8'($urandom), 1'b1);
    v[0] = 1'b0; v[1] = 1'b0;

    // Timeout with a late ack during the bus gap.
    v[0] = 1'b1; rw[0] = 1'b0; adr[0] = 8'h42;
    do_txn(1'b1, 0, 8'h00, 1'b0);
    drive();

    // Spurious ack while idle.
    bus.sbacko = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("spur_done", {6'd0, bus.rsp1_done, bus.rsp0_done}, 8'd0);
      chk("spur_busy", {7'd0, bus.busy}, 8'd0);
      step();
    end
    bus.sbacko = 1'b0;

    // Reset in the middle of a strobe.
    v[0] = 1'b1; rw[0] = 1'b1; adr[0] = 8'h77; dat[0] = 8'h11;
    drive();
    step();
    v[0] = 1'b0;
    drive();
    step();
    @(negedge clk);
    chk("mid_stb", {7'd0, bus.sbstbi}, 8'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_async_stb", {7'd0, bus.sbstbi}, 8'd0);
    chk("rst_async_busy", {7'd0, bus.busy}, 8'd0);
    chk("rst_async_done", {6'd0, bus.rsp1_done, bus.rsp0_done}, 8'd0);
    m_last = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", {6'd0, bus.rsp1_done, bus.rsp0_done}, 8'd0);
    step();
    v[0] = 1'b1; v[1] = 1'b1;
    do_txn(1'b0, 1, 8'($urandom), 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!v[r] && $urandom_range(0, 1) == 1) begin
          v[r]   = 1'b1;
          rw[r]  = 1'($urandom);
          adr[r] = 8'($urandom);
          dat[r] = 8'($urandom);
        end
      end
      if (!v[0] && !v[1]) v[$urandom_range(0, 1)] = 1'b1;
      do_txn(1'($urandom_range(0, 1)), int'($urandom_range(1, 6)),
             8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sb_i2c_bus_arbiter.md
# sb_i2c_bus_arbiter

Two-port arbiter and sequencer for the SB_I2C hard-IP system bus. It accepts register read/write requests from two independent fabric requesters and grants them round-robin. It drives the strobe/ack handshake on the shared SBSTBI/SBRWI/SBADRI/SBDATI bus and returns SBDATO read data to the owning requester. It sits between fabric control logic and one or more SB_I2C instances, which are address-decoded by SBADRI[7:4] (BUS_ADDR74).

## Interface

Parameters:
- TIMEOUT, 255: maximum STROBE cycles to wait for sbacko; legal range 1..255; timeout counter is 8 bits.

Ports:
- sbclki  in  1  system bus clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req0_valid  in  1  requester 0 has a transaction pending.
- req0_rw  in  1  1 = write, 0 = read.
- req0_adr  in  8  SB register address.
- req0_dat  in  8  write data.
- req0_acc  out  1  request 0 accepted this cycle.
- req1_valid, req1_rw, req1_adr, req1_dat, req1_acc: same as port 0, for requester 1.
- rsp0_done  out  1  one-cycle pulse; transaction for requester 0 finished.
- rsp1_done  out  1  one-cycle pulse; transaction for requester 1 finished.
- rsp_err  out  1  qualifies rspN_done; 1 = timeout.
- rsp_dat  out  8  read data; valid while rspN_done is high.
- busy  out  1  arbiter is not in IDLE.
- sbstbi  out  1  bus strobe.
- sbrwi  out  1  bus write enable.
- sbadri  out  8  bus address.
- sbdati  out  8  bus write data.
- sbdato  in  8  bus read data, OR of all IP outputs.
- sbacko  in  1  bus acknowledge, OR of all IP outputs.

## Operation

FSM states:
- IDLE
  - reqN_acc is combinational: state==IDLE & reqN_valid & granted(N).
  - On an accept edge: latch rw/adr/dat into the bus registers, record the owner, go to STROBE.
- STROBE
  - sbstbi=1; bus fields held stable.
  - Each cycle, sample sbacko.
  - If sbacko=1: capture rsp_dat = sbdato when rw=0, or 0x00 for a write; pulse the owner's done; go to DONE.
  - Otherwise increment the timeout counter.
  - When counter == TIMEOUT-1 with no ack: pulse done with rsp_err=1, rsp_dat=0x00, go to DONE.
- DONE
  - sbstbi=0, for exactly one cycle of bus gap; go to IDLE.
  - The timeout counter clears on entry to STROBE.

Arbitration:
- Round-robin on a last-owner bit; reset value 1, so requester 0 wins the first contention.
- If only one requester is valid, it is granted regardless of the last owner.
- If both are valid, the requester that is not the last owner wins.
- The last owner updates on accept.

Request rules:
- Requesters hold valid and their fields stable until acc.
- Fields may change after acc.
- valid dropped before acc: no transaction.

Other behaviour:
- sbacko arriving in IDLE or DONE is ignored.
- sbadri/sbdati/sbrwi retain their last values outside STROBE.
- A late ack after a timeout does not generate a second done.
- busy = (state != IDLE).

## Timing

- Reset values: sbstbi=0, sbrwi=0, sbadri=0x00, sbdati=0x00, reqN_acc=0, rspN_done=0, rsp_err=0, rsp_dat=0x00, busy=0, state=IDLE, last owner=1.
- rst_n low mid-transaction drops sbstbi asynchronously. No done pulse is issued, and the in-flight transaction is lost.
- Cycle 0: acc high (IDLE). Cycle 1: sbstbi high. If sbacko is high in cycle k ≥ 1, done is high and sbstbi low in cycle k+1, and IDLE is reached in cycle k+2.
- Minimum latency from acc to done is 2 cycles. Back-to-back transactions have acc every 3 cycles minimum.
- Timeout: done with rsp_err=1 occurs in cycle TIMEOUT+1 after acc.
- All outputs except reqN_acc are registered.

## Test plan

- Single read: req0 adr=0x19, ack in the 2nd STROBE cycle with sbdato=0xA5 → sbstbi high for 2 cycles, sbrwi=0, sbadri=0x19; rsp0_done with rsp_dat=0xA5, rsp_err=0; rsp1_done stays 0.
- Single write: req1 rw=1 adr=0x38 dat=0x5C, immediate ack → sbrwi=1, sbdati=0x5C; rsp1_done 2 cycles after acc with rsp_dat=0x00.
- Contention: both valid from reset, continuously → acc order 0,1,0,1; each acc spaced by exactly 3 cycles with immediate acks; sbstbi low ≥1 cycle between strobes.
- Timeout: TIMEOUT=4, no sbacko → sbstbi high for 4 cycles; done with rsp_err=1, rsp_dat=0x00; a late sbacko in DONE produces no extra done.
- Reset mid-op: assert rst_n low during STROBE → sbstbi=0 immediately, no done. After release, req0 is granted first under contention.
- Spurious ack: sbacko pulsed in IDLE → no done, busy stays 0.
